// File: rtl/fa.sv
// rtl/fa.sv - 1-bit full adder
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder, LSB first, one bit per clock
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fa_s, fa_c;
    logic             last_bit;

    fa u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // The counter stops at WIDTH-1; that value marks the edge that adds the final bit.
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Next-state and datapath: capture in IDLE, one bit per edge in SHIFT, single-cycle DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                if (last_bit) begin
                    // Publish the result including the bit being added on this edge.
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rstn;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int errors = 0;
    int checks = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t counts edges since acceptance (0 = idle). Result appears WIDTH+1 edges
    // after acceptance, held one cycle as done, then idle again.
    int           t;
    logic [W:0]   m_exp;
    logic [W-1:0] m_sum;
    logic         m_cout;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            t      <= 0;
            m_exp  <= '0;
            m_sum  <= '0;
            m_cout <= 1'b0;
        end else if (t == 0) begin
            if (start) begin
                t     <= 1;
                m_exp <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            end
        end else if (t == W) begin
            t      <= W + 1;
            m_sum  <= m_exp[W-1:0];
            m_cout <= m_exp[W];
        end else if (t == W + 1) begin
            t <= 0;
        end else begin
            t <= t + 1;
        end
    end

    logic cmp_en = 1'b0;

    // Compare DUT against the model every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {31'd0, busy}, {31'd0, (t >= 1 && t <= W)});
            chk("done", {31'd0, done}, {31'd0, (t == W + 1)});
            chk("sum",  {24'd0, sum},  {24'd0, m_sum});
            chk("cout", {31'd0, cout}, {31'd0, m_cout});
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic [W-1:0] es, input logic ec, input string name);
        int n;
        int busy_cnt;
        a     = ta;
        b     = tb_;
        cin   = tc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        n        = 1;
        busy_cnt = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, n, 9);
        chk({name, "_busy_cycles"}, busy_cnt, 8);
        chk({name, "_sum"}, {24'd0, sum}, {24'd0, es});
        chk({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int cyc;
        int done_cnt;
        rstn   = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_sum",  {24'd0, sum},  32'd0);
        chk("reset_cout", {31'd0, cout}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "op_0f_01");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "op_ff_01");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "op_ff_ff_c");
        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "op_zero");
        run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "op_cin_only");

        // Start held high with fresh operands every cycle.
        start = 1'b1;
        last  = -1;
        for (int i = 0; i < 45; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            @(posedge clk);
            #1;
            if (done) begin
                if (last >= 0) chk("done_period", i - last, 10);
                last = i;
            end
        end
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // Reset in the 4th SHIFT cycle, then a fresh operation.
        a     = 8'h5A;
        b     = 8'h33;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_done", {31'd0, done}, 32'd0);
        chk("async_sum",  {24'd0, sum},  32'd0);
        chk("async_cout", {31'd0, cout}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        run_op(8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, "op_after_rst");

        // Random operands and random start gaps; the compare process checks each result.
        done_cnt = 0;
        cyc      = 0;
        while (done_cnt < 500 && cyc < 20000) begin
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            @(posedge clk);
            #1;
            if (done) done_cnt++;
            cyc++;
        end
        start = 1'b0;
        chk("random_ops", done_cnt, 500);
        repeat (12) @(posedge clk);
        #1;
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand and sum width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 SHALL have port a  input  WIDTH  first operand; captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  second operand; captured on accepted start.
REQ-007 SHALL have port cin  input  1  carry-in; captured on accepted start.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-010 SHALL have port sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-011 SHALL have port cout  output  1  registered carry-out of the addition.

Function
REQ-012 SHALL compute the result bit-serially, LSB first, through one instance of the team's 1-bit full adder (fa), one bit per clk cycle.
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE, encoded in a registered state variable.
REQ-014 SHALL accept start only in IDLE: on that edge, load a and b into internal shift registers, load cin into the carry flop, clear the bit counter, enter SHIFT.
REQ-015 SHALL ignore start while in SHIFT or DONE; captured operands and progress SHALL NOT change.
REQ-016 SHALL, on each SHIFT edge, feed the fa with A[0], B[0], carry; shift the fa sum bit into the MSB of the internal result register; shift A and B right by one; load the fa carry-out into the carry flop; increment the counter.
REQ-017 SHALL leave SHIFT after exactly WIDTH SHIFT edges, without wrapping the counter, and enter DONE.
REQ-018 SHALL, on the edge that completes the final bit, load sum from the internal result register (including that final bit) and load cout from the final fa carry-out.
REQ-019 SHALL hold sum and cout stable from that edge until the final edge of the next accepted operation.
REQ-020 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-021 SHALL drive busy high in SHIFT only, and low in IDLE and DONE.
REQ-022 SHALL give latency from the accepting edge to done high of WIDTH+1 rising edges; the next start SHALL be accepted at the earliest one edge after done.
REQ-023 SHALL produce a result that equals {cout,sum} == a+b+cin for all operand values, including all-zeros and all-ones.
REQ-024 SHALL register busy, done, sum and cout; none SHALL depend combinationally on inputs.

Reset
REQ-025 SHALL, on rstn low at any time (including mid-SHIFT), immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, and clear counter, carry and shift registers.
REQ-026 SHALL leave reset in IDLE, and SHALL accept start no earlier than the first rising clk after rstn deasserts.

Verification
REQ-027 WIDTH=8, a=0x0F b=0x01 cin=0, start one cycle -> busy high 8 cycles, done pulse on edge 9 after accept, sum=0x10 cout=0.
REQ-028 WIDTH=8, a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1; then a=0xFF b=0xFF cin=1 -> sum=0xFF cout=1.
REQ-029 Start held high continuously with new a/b each cycle -> only the operands present at each IDLE accept are used; results match those operands; done pulses every 10 cycles.
REQ-030 rstn pulsed low during the 4th SHIFT cycle -> busy, done, sum, cout go 0 asynchronously; next start yields a correct fresh result.
REQ-031 500 random a/b/cin with random start gaps -> every done matches {cout,sum}==a+b+cin; sum and cout unchanged while busy.
